// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between IDU and EXU: counts outstanding writes per register and
// holds issue on RAW or counter saturation. Define SCOREBOARD_WB_BYPASS_EN for same-cycle release.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PEND_W   = 2,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_rs1_used,
    input  logic              in_rs2_used,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_wen,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              err_underflow
);
    localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    logic [PEND_W-1:0]   pend_q [NUM_REGS];
    logic [PEND_W-1:0]   pend_d [NUM_REGS];
    logic [PERF_W-1:0]   stall_q, stall_d;
    logic                err_q, err_d;
    logic [PEND_W-1:0]   rs1_pend, rs2_pend, rd_pend;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic                hazard, fire;

    always_comb begin
        rs1_pend = pend_q[in_rs1];
        rs2_pend = pend_q[in_rs2];
        rd_pend  = pend_q[in_rd];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // A write retiring this cycle no longer counts against issue; EXU forwards the WB data.
        if (wb_valid && wb_rd == in_rs1 && rs1_pend != '0) rs1_pend = rs1_pend - PendOne;
        if (wb_valid && wb_rd == in_rs2 && rs2_pend != '0) rs2_pend = rs2_pend - PendOne;
        if (wb_valid && wb_rd == in_rd && rd_pend != '0) rd_pend = rd_pend - PendOne;
`endif
        hazard = (in_rs1_used && in_rs1 != '0 && rs1_pend != '0) ||
                 (in_rs2_used && in_rs2 != '0 && rs2_pend != '0) ||
                 (in_rd_wen && in_rd != '0 && rd_pend == PendMax);
    end

    assign out_valid = in_valid & ~hazard & ~rst;
    assign in_ready  = out_ready & ~hazard & ~rst;
    assign fire      = out_valid & out_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (fire && in_rd_wen && in_rd != '0) inc_vec[in_rd] = 1'b1;
        if (wb_valid && wb_rd != '0) dec_vec[wb_rd] = 1'b1;
    end

    always_comb begin
        err_d     = err_q;
        stall_d   = stall_q;
        pend_d[0] = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
            if (flush) begin
                pend_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                pend_d[i] = pend_q[i] + PendOne;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (pend_q[i] == '0) err_d = 1'b1;
                else pend_d[i] = pend_q[i] - PendOne;
            end
        end
        if (in_valid && hazard && !flush) stall_d = stall_q + PERF_W'(1);
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) busy = busy | (pend_q[i] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios plus randomized traffic
// compared every cycle against a counting model of outstanding writes.
module tb_reg_scoreboard;
    localparam int NR      = 32;
    localparam int MaxPend = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_rs1_used = 1'b0, in_rs2_used = 1'b0, in_rd_wen = 1'b0;
    logic        out_ready = 1'b1, wb_valid = 1'b0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0;
    logic        out_valid, in_ready, busy, err_underflow;
    logic [31:0] stall_cycles;

    int          errors = 0, checks = 0;
    int          m_pend [NR];
    bit          m_err;
    logic [31:0] m_stall;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy(busy), .stall_cycles(stall_cycles), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Outstanding writes a register still has from the point of view of issue this cycle.
    function automatic int eff(input logic [4:0] r);
        int p;
        p = m_pend[r];
        if (Byp && wb_valid && wb_rd == r && p > 0) p = p - 1;
        return p;
    endfunction

    function automatic bit model_hazard();
        return (in_rs1_used && in_rs1 != 0 && eff(in_rs1) > 0) ||
               (in_rs2_used && in_rs2 != 0 && eff(in_rs2) > 0) ||
               (in_rd_wen && in_rd != 0 && eff(in_rd) == MaxPend);
    endfunction

    always @(negedge clk) begin
        bit hz, fires, any;
        int inc_r, ret_r;
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_stall", stall_cycles, 0);
            chk("rst_err", 32'(err_underflow), 0);
            foreach (m_pend[i]) m_pend[i] = 0;
            m_err   = 1'b0;
            m_stall = '0;
        end else begin
            hz  = model_hazard();
            any = 1'b0;
            foreach (m_pend[i]) if (m_pend[i] != 0) any = 1'b1;
            chk("out_valid", 32'(out_valid), 32'(in_valid && !hz));
            chk("in_ready", 32'(in_ready), 32'(out_ready && !hz));
            chk("busy", 32'(busy), 32'(any));
            chk("stall_cycles", stall_cycles, m_stall);
            chk("err_underflow", 32'(err_underflow), 32'(m_err));
            fires = in_valid && !hz && out_ready;
            inc_r = (fires && in_rd_wen && in_rd != 0) ? int'(in_rd) : 0;
            ret_r = (wb_valid && wb_rd != 0) ? int'(wb_rd) : 0;
            if (in_valid && hz && !flush) m_stall = m_stall + 1;
            if (flush) begin
                foreach (m_pend[i]) m_pend[i] = 0;
            end else if (!(inc_r != 0 && inc_r == ret_r)) begin
                if (inc_r != 0) m_pend[inc_r]++;
                if (ret_r != 0) begin
                    if (m_pend[ret_r] == 0) m_err = 1'b1;
                    else m_pend[ret_r]--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1_used = 0; in_rs2_used = 0; in_rd_wen = 0;
        wb_valid = 0; flush = 0; out_ready = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // RAW on x5
        idle(); in_valid = 1; in_rd = 5; in_rd_wen = 1;
        #2 chk("raw_issue", 32'(out_valid), 1);
        tick(); in_rd_wen = 0; in_rs1 = 5; in_rs1_used = 1;
        #2 chk("raw_stall", 32'(out_valid), 0); chk("raw_busy", 32'(busy), 1);
        tick();
        #2 chk("raw_stall_cnt1", stall_cycles, 1);
        tick(); wb_valid = 1; wb_rd = 5;
        #2 chk("raw_wb_cycle", 32'(out_valid), 32'(Byp)); chk("raw_stall_cnt2", stall_cycles, 2);
        tick(); wb_valid = 0;
        #2 chk("raw_release", 32'(out_valid), 1);
        chk("raw_stall_total", stall_cycles, Byp ? 32'd2 : 32'd3);
        tick(); idle(); tick();

        // x0 never tracked
        in_valid = 1; in_rd = 0; in_rd_wen = 1;
        #2 chk("x0_issue", 32'(out_valid), 1);
        tick(); in_rd_wen = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 1; in_rs2_used = 1;
        #2 chk("x0_src", 32'(out_valid), 1); chk("x0_busy", 32'(busy), 0);
        tick(); idle();

        // saturation on x7
        in_valid = 1; in_rd = 7; in_rd_wen = 1;
        for (int k = 0; k < 3; k++) begin
            #2 chk("sat_issue", 32'(out_valid), 1);
            tick();
        end
        #2 chk("sat_stall", 32'(out_valid), 0); chk("sat_in_ready", 32'(in_ready), 0);
        tick(); wb_valid = 1; wb_rd = 7;
        #2 chk("sat_wb_cycle", 32'(out_valid), 32'(Byp));
        tick(); wb_valid = 0;
        #2 chk("sat_release", 32'(out_valid), 32'(!Byp));
        tick(); idle(); tick();

        // simultaneous issue and retire of x3
        in_valid = 1; in_rd = 3; in_rd_wen = 1;
        tick(); wb_valid = 1; wb_rd = 3;
        #2 chk("simul_fire", 32'(out_valid), 1);
        tick(); wb_valid = 0; in_rd_wen = 0; in_rs1 = 3; in_rs1_used = 1;
        #2 chk("simul_pend_held", 32'(out_valid), 0); chk("simul_no_err", 32'(err_underflow), 0);
        tick(); idle();

        // underflow then flush
        wb_valid = 1; wb_rd = 9;
        tick(); wb_valid = 0;
        #2 chk("uf_set", 32'(err_underflow), 1);
        tick();
        #2 chk("uf_sticky", 32'(err_underflow), 1); chk("uf_busy_pre", 32'(busy), 1);
        flush = 1;
        tick(); flush = 0;
        #2 chk("flush_busy", 32'(busy), 0); chk("flush_keeps_err", 32'(err_underflow), 1);
        tick();

        // asynchronous reset with pend[5]=2
        in_valid = 1; in_rd = 5; in_rd_wen = 1;
        tick(); tick(); in_rd_wen = 0; in_rs1 = 5; in_rs1_used = 1;
        #2 chk("mid_busy", 32'(busy), 1);
        rst = 1;
        #1 chk("mid_rst_busy", 32'(busy), 0); chk("mid_rst_stall", stall_cycles, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0); chk("mid_rst_err", 32'(err_underflow), 0);
        tick(); rst = 0;
        #2 chk("post_rst_issue", 32'(out_valid), 1);
        tick(); idle();

        // randomized traffic on a narrow register range to force hazards
        repeat (3000) begin
            in_valid    = $urandom_range(0, 3) != 0;
            in_rs1      = 5'($urandom_range(0, 7));
            in_rs2      = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom_range(0, 7));
            in_rs1_used = $urandom_range(0, 1) != 0;
            in_rs2_used = $urandom_range(0, 1) != 0;
            in_rd_wen   = $urandom_range(0, 3) != 0;
            out_ready   = $urandom_range(0, 3) != 0;
            wb_valid    = $urandom_range(0, 2) == 0;
            wb_rd       = 5'($urandom_range(0, 7));
            flush       = $urandom_range(0, 40) == 0;
            tick();
        end
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
